// File: rtl/serdesphy_rx_framer.sv
// serdesphy_rx_framer
//   Receive-side frame aligner. Hunts for SYNC_WORD in the recovered serial
//   stream, confirms alignment over LOCK_COUNT frames, then delivers aligned
//   payload bytes. MISS_LIMIT consecutive missed syncs drop back to hunting.
//
//   Optional feature macro: SERDESPHY_RX_INVERT_DETECT_EN
//     When defined, an inverted sync byte is also accepted while hunting and
//     the remainder of the stream is re-inverted before use.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   rx_bit       in   recovered serial bit, MSB of each byte first
//   rx_bit_valid in   qualifies rx_bit; low holds all state
//   data_out     out  aligned payload byte
//   data_valid   out  one-cycle pulse, data_out updated
//   locked       out  high while frame alignment is locked
//   sync_err     out  one-cycle pulse on a missed sync while locked
//   rx_inverted  out  stream polarity inverted flag
module serdesphy_rx_framer #(
   parameter logic [7:0]  SYNC_WORD   = 8'hA7,
   parameter int unsigned FRAME_BYTES = 4,
   parameter int unsigned LOCK_COUNT  = 3,
   parameter int unsigned MISS_LIMIT  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_bit,
   input  logic       rx_bit_valid,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       locked,
   output logic       sync_err,
   output logic       rx_inverted
);

   localparam int unsigned FrameBits = 8 * (FRAME_BYTES + 1);
   localparam logic [7:0]  SlotCnt   = 8'(FrameBits - 1);
   localparam logic [2:0]  LockCnt   = 3'(LOCK_COUNT);
   localparam logic [2:0]  MissLim   = 3'(MISS_LIMIT);

   typedef enum logic [1:0] {StHunt, StVerify, StLocked} state_e;

   state_e     state_q, state_d;
   // Only the low 7 bits of the shift register feed the next window.
   logic [6:0] sr_q, sr_d;
   logic [7:0] bit_cnt_q, bit_cnt_d;
   logic [2:0] good_q, good_d;
   logic [2:0] miss_q, miss_d;
   logic [7:0] data_d;
   logic       valid_d, err_d;
   logic       inv_q;
   logic       b;
   logic [7:0] w;
   logic       hit, go_hunt;
`ifdef SERDESPHY_RX_INVERT_DETECT_EN
   logic       inv_d;
`endif

   always_comb begin
      state_d   = state_q;
      sr_d      = sr_q;
      bit_cnt_d = bit_cnt_q;
      good_d    = good_q;
      miss_d    = miss_q;
      data_d    = data_out;
      valid_d   = 1'b0;
      err_d     = 1'b0;
      hit       = 1'b0;
      go_hunt   = 1'b0;
`ifdef SERDESPHY_RX_INVERT_DETECT_EN
      inv_d     = inv_q;
`endif
      b = rx_bit ^ inv_q;
      w = {sr_q, b};

      if (rx_bit_valid) begin
         sr_d = w[6:0];
         unique case (state_q)
            StHunt: begin
               hit = (w == SYNC_WORD);
`ifdef SERDESPHY_RX_INVERT_DETECT_EN
               // Inverted sync: flip polarity and pretend the true sync arrived.
               if (!hit && (w == ~SYNC_WORD)) begin
                  hit   = 1'b1;
                  inv_d = 1'b1;
                  sr_d  = SYNC_WORD[6:0];
               end
`endif
               if (hit) begin
                  state_d   = (LOCK_COUNT == 1) ? StLocked : StVerify;
                  bit_cnt_d = '0;
                  good_d    = 3'd1;
                  miss_d    = '0;
               end
            end
            StVerify: begin
               if (bit_cnt_q == SlotCnt) begin
                  bit_cnt_d = '0;
                  if (w == SYNC_WORD) begin
                     good_d = good_q + 3'd1;
                     if (good_d == LockCnt) begin
                        state_d = StLocked;
                        miss_d  = '0;
                     end
                  end else begin
                     go_hunt = 1'b1;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 8'd1;
               end
            end
            StLocked: begin
               if (bit_cnt_q == SlotCnt) begin
                  bit_cnt_d = '0;
                  if (w == SYNC_WORD) begin
                     miss_d = '0;
                  end else begin
                     err_d  = 1'b1;
                     miss_d = miss_q + 3'd1;
                     if (miss_d == MissLim) go_hunt = 1'b1;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 8'd1;
                  // Outside the slot bit, every byte boundary closes a payload byte.
                  if (bit_cnt_q[2:0] == 3'd7) begin
                     data_d  = w;
                     valid_d = 1'b1;
                  end
               end
            end
            default: go_hunt = 1'b1;
         endcase

         if (go_hunt) begin
            state_d   = StHunt;
            bit_cnt_d = '0;
            good_d    = '0;
            miss_d    = '0;
`ifdef SERDESPHY_RX_INVERT_DETECT_EN
            inv_d     = 1'b0;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StHunt;
         sr_q       <= '0;
         bit_cnt_q  <= '0;
         good_q     <= '0;
         miss_q     <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         sync_err   <= 1'b0;
         locked     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sr_q       <= sr_d;
         bit_cnt_q  <= bit_cnt_d;
         good_q     <= good_d;
         miss_q     <= miss_d;
         data_out   <= data_d;
         data_valid <= valid_d;
         sync_err   <= err_d;
         locked     <= (state_d == StLocked);
      end
   end

`ifdef SERDESPHY_RX_INVERT_DETECT_EN
   always_ff @(posedge clk) begin
      if (rst) inv_q <= 1'b0;
      else     inv_q <= inv_d;
   end
   assign rx_inverted = inv_q;
`else
   assign inv_q       = 1'b0;
   assign rx_inverted = 1'b0;
`endif

endmodule

// File: tb/tb_serdesphy_rx_framer.sv
// Self-checking bench for serdesphy_rx_framer. A frame-level reference model
// locates syncs by index arithmetic over the recorded bit stream and predicts,
// per valid bit, data_valid/data_out/sync_err/locked/rx_inverted.
module tb_serdesphy_rx_framer;

   localparam logic [7:0]  Sync       = 8'hA7;
   localparam int unsigned FrameBytes = 4;
   localparam int unsigned LockCount  = 3;
   localparam int unsigned MissLimit  = 2;
   localparam int          FrameBits  = 8 * (FrameBytes + 1);
`ifdef SERDESPHY_RX_INVERT_DETECT_EN
   localparam bit InvEn = 1'b1;
`else
   localparam bit InvEn = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_bit;
   logic       rx_bit_valid;
   logic [7:0] data_out;
   logic       data_valid;
   logic       locked;
   logic       sync_err;
   logic       rx_inverted;

   always #5 clk = ~clk;

   serdesphy_rx_framer #(
      .SYNC_WORD   (Sync),
      .FRAME_BYTES (FrameBytes),
      .LOCK_COUNT  (LockCount),
      .MISS_LIMIT  (MissLimit)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_bit       (rx_bit),
      .rx_bit_valid (rx_bit_valid),
      .data_out     (data_out),
      .data_valid   (data_valid),
      .locked       (locked),
      .sync_err     (sync_err),
      .rx_inverted  (rx_inverted)
   );

   int         checks = 0;
   int         errors = 0;
   bit         raw[$];
   bit         eff[];
   bit         e_dv[], e_serr[], e_lock[], e_inv[];
   logic [7:0] e_byte[], e_data[];
   logic [7:0] got[$];
   bit         saw_lock;
   logic [7:0] pat [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) raw.push_back(v[i]);
   endtask

   task automatic push_frame(input logic [7:0] s, input logic [31:0] pay);
      push_byte(s);
      push_byte(pay[31:24]);
      push_byte(pay[23:16]);
      push_byte(pay[15:8]);
      push_byte(pay[7:0]);
   endtask

   // Last 8 effective bits ending at index m; bits before reset count as 0.
   function automatic logic [7:0] win(int m);
      logic [7:0] v = '0;
      for (int i = 0; i < 8; i++) begin
         int idx = m - 7 + i;
         v = {v[6:0], (idx >= 0) ? eff[idx] : 1'b0};
      end
      return v;
   endfunction

   function automatic void flip_from(int a);
      for (int i = (a < 0) ? 0 : a; i < eff.size(); i++) eff[i] = ~eff[i];
   endfunction

   // Frame model: find a hunt match h, then sync slots sit at h + k*FrameBits.
   task automatic build_model();
      int         nb = raw.size();
      int         n, h, k, good, misses, slot, fstart;
      bit         lk, inv, done;
      logic [7:0] last;
      eff = new[nb]; e_dv = new[nb]; e_serr = new[nb]; e_lock = new[nb];
      e_inv = new[nb]; e_byte = new[nb]; e_data = new[nb];
      for (int m = 0; m < nb; m++) begin
         eff[m] = raw[m]; e_dv[m] = 0; e_serr[m] = 0; e_lock[m] = 0;
         e_inv[m] = 0; e_byte[m] = 8'h00;
      end
      n = 0;
      while (n < nb) begin
         h = -1;
         inv = 0;
         for (int m = n; m < nb; m++) begin
            if (win(m) == Sync) begin h = m; break; end
            if (InvEn && win(m) == ~Sync) begin h = m; inv = 1; flip_from(m - 7); break; end
         end
         if (h < 0) break;
         good = 1; misses = 0; lk = (LockCount == 1);
         e_lock[h] = lk; e_inv[h] = inv;
         done = 0; k = 1;
         while (!done) begin
            fstart = h + (k - 1) * FrameBits + 1;
            slot   = h + k * FrameBits;
            for (int m = fstart; m <= slot && m < nb; m++) begin
               e_lock[m] = lk; e_inv[m] = inv;
               if (lk && m != slot && ((m - fstart) % 8) == 7) begin
                  e_dv[m] = 1; e_byte[m] = win(m);
               end
            end
            if (slot >= nb) begin
               n = nb; done = 1;
            end else if (win(slot) == Sync) begin
               misses = 0;
               if (!lk) begin good++; if (good == LockCount) lk = 1; end
               e_lock[slot] = lk;
               k++;
            end else begin
               if (lk) begin e_serr[slot] = 1; misses++; end
               if (!lk || misses == MissLimit) begin
                  e_lock[slot] = 0; e_inv[slot] = 0;
                  if (inv) flip_from(slot + 1);
                  n = slot + 1; done = 1;
               end else begin
                  k++;
               end
            end
         end
      end
      last = 8'h00;
      for (int m = 0; m < nb; m++) begin
         if (e_dv[m]) last = e_byte[m];
         e_data[m] = last;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) begin
         rx_bit_valid = 1'($urandom);
         rx_bit       = 1'($urandom);
         @(posedge clk);
      end
      #1;
      check("rst_data", data_out, 8'h00);
      check("rst_dv", data_valid, 1'b0);
      check("rst_lock", locked, 1'b0);
      check("rst_serr", sync_err, 1'b0);
      check("rst_inv", rx_inverted, 1'b0);
      rst = 1'b0;
      rx_bit_valid = 1'b0;
   endtask

   // Drives raw[] from the post-reset state, with up to max_gap idle cycles per bit.
   task automatic drive(input int max_gap);
      bit         pl = 0;
      bit         pi = 0;
      logic [7:0] pd = 8'h00;
      int         gaps;
      build_model();
      got.delete();
      saw_lock = 0;
      for (int n = 0; n < raw.size(); n++) begin
         gaps = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
         for (int g = 0; g < gaps; g++) begin
            rx_bit_valid = 1'b0;
            rx_bit       = 1'($urandom);
            @(posedge clk); #1;
            check("gap_pulses", {data_valid, sync_err}, 2'b00);
            check("gap_hold", {data_out, locked, rx_inverted}, {pd, pl, pi});
         end
         rx_bit       = raw[n];
         rx_bit_valid = 1'b1;
         @(posedge clk); #1;
         check("dv", data_valid, e_dv[n]);
         check("serr", sync_err, e_serr[n]);
         check("lock", locked, e_lock[n]);
         check("inv", rx_inverted, e_inv[n]);
         check("data", data_out, e_data[n]);
         if (data_valid) got.push_back(data_out);
         if (locked) saw_lock = 1;
         pl = e_lock[n]; pi = e_inv[n]; pd = e_data[n];
      end
      rx_bit_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      rx_bit = 1'b0;
      rx_bit_valid = 1'b0;

      // Reset, then a long idle stretch with noise on rx_bit.
      do_reset();
      repeat (200) begin
         rx_bit = 1'($urandom);
         rx_bit_valid = 1'b0;
         @(posedge clk); #1;
         check("idle", {data_out, data_valid, locked, sync_err, rx_inverted}, 12'h000);
      end

      // Lock, single miss, double miss, failed verify, relock, random payload.
      raw.delete();
      for (int f = 0; f < 4; f++) push_frame(Sync, 32'h11223344);
      push_frame(8'hA6, 32'h11223344);
      for (int f = 0; f < 2; f++) push_frame(Sync, 32'h11223344);
      for (int f = 0; f < 2; f++) push_frame(8'hA6, 32'h11223344);
      for (int f = 0; f < 2; f++) push_frame(Sync, 32'h11223344);
      push_frame(8'hA6, 32'h11223344);
      for (int f = 0; f < 3; f++) push_frame(Sync, 32'h11223344);
      for (int f = 0; f < 2; f++) push_frame(Sync, $urandom);
      push_byte(Sync);
      for (int i = 0; i < 13; i++) raw.push_back(1'($urandom));
      drive(0);
      check("a_min_bytes", got.size() >= 8, 1'b1);
      for (int i = 0; i < 8 && i < got.size(); i++) check("a_byte", got[i], pat[i % 4]);

      // Reset lands mid-frame while locked.
      do_reset();

      // Random prefix plus idle gaps.
      raw.delete();
      for (int i = 0; i < 5; i++) raw.push_back(1'($urandom));
      for (int f = 0; f < 6; f++) push_frame(Sync, 32'h11223344);
      drive(3);
      check("b_count", got.size(), 16);
      for (int i = 0; i < got.size(); i++) check("b_byte", got[i], pat[i % 4]);

      // Random payload and randomly corrupted syncs.
      do_reset();
      raw.delete();
      for (int f = 0; f < 12; f++)
         push_frame(($urandom_range(0, 3) == 0) ? 8'($urandom) : Sync, $urandom);
      drive(2);

      // Bitwise-inverted stream.
      do_reset();
      raw.delete();
      for (int f = 0; f < 6; f++) push_frame(~Sync, ~32'h11223344);
      drive(0);
      check("inv_saw_lock", saw_lock, InvEn);
      check("inv_flag_end", rx_inverted, InvEn);
      check("inv_count", got.size(), InvEn ? 16 : 0);
      for (int i = 0; i < got.size(); i++) check("inv_byte", got[i], pat[i % 4]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
